sr_pipe_ctrl: RTL
=================

// Module: sr_pipe_ctrl
// PURPOSE
// - Central sequencer for the 4-stage schoolRISCV pipeline (fetch/decode/execute/writeback).
// - Owns PC-next selection, F/D hold, D/E bubble insertion, branch stall/redirect FSM and operand-forwarding selects.
// - Sits beside the register file; all stage registers take their enables/flushes from it.
// PARAMETERS
// - BR_LAT    default 2   max cycles from branch leaving decode to br_res_i; range 1..7
// - RESET_PC  default 0   first fetch address after reset
// - CNT_W     default 32  perf counter width
// PORTS
// - clk          in   1      clock, rising edge
// - rst_n        in   1      asynchronous active-low reset
// - br_d_i       in   1      decode stage holds a branch
// - pc4_d_i      in   32     decode-stage PC+4 (branch fall-through)
// - pc4_f_i      in   32     fetch-stage PC+4 (sequential next PC)
// - br_res_i     in   1      branch resolution valid (writeback)
// - br_taken_i   in   1      resolved branch taken
// - br_tgt_i     in   32     resolved branch target
// - rs1_d_i      in   5      decode source 1
// - rs2_d_i      in   5      decode source 2
// - rd_e_i       in   5      execute dest;  regwr_e_i in 1 its write enable
// - rd_w_i       in   5      writeback dest; regwr_w_i in 1 its write enable
// - pc_next_o    out  32     registered next PC to fetch
// - pc_we_o      out  1      fetch PC update enable
// - fd_hold_o    out  1      hold F/D register
// - de_bubble_o  out  1      load NOP into D/E register
// - fwd_a_o      out  2      srcA select: 00 regfile, 01 execute result, 10 writeback result
// - fwd_b_o      out  2      srcB select, same encoding
// - err_o        out  1      sticky: resolution timeout or stray br_res_i
// - state_o      out  2      FSM state (debug)
// - perf_clr_i   in   1      clear perf counters
// - perf_stall_o out  CNT_W  stall-cycle count;  perf_br_o out CNT_W taken-branch count
// BEHAVIOUR
// - Reset: state=BOOT, pc_next_o=RESET_PC, pc_we_o=0, fd_hold_o=1, de_bubble_o=1, fwd=00, err_o=0, counters 0.
// - States: BOOT=00, RUN=01, BR_WAIT=10, REDIRECT=11; pc_we/fd_hold/de_bubble are combinational from state(+br_d_i).
// - BOOT: one cycle after rst_n release; pc_we_o=1 (fetch RESET_PC), pc_next_o<=RESET_PC+4? no: pc_next_o stays RESET_PC; -> RUN.
// - RUN: pc_we_o=!br_d_i, fd_hold_o=br_d_i, de_bubble_o=0; pc_next_o<=pc4_f_i when !br_d_i.
//   br_d_i=1: capture pc4_d_i into fallthrough reg, wait cnt<=BR_LAT, -> BR_WAIT.
// - BR_WAIT: pc_we_o=0, fd_hold_o=1, de_bubble_o=1; cnt decrements each cycle; br_d_i ignored.
//   br_res_i=1: pc_next_o<=br_taken_i ? br_tgt_i : fallthrough; -> REDIRECT.
//   cnt reaches 0 without br_res_i: err_o<=1, pc_next_o<=fallthrough, -> REDIRECT.
// - REDIRECT: pc_we_o=1, fd_hold_o=0, de_bubble_o=1 (flush stale F/D); -> RUN. Branch penalty = BR_LAT+2 cycles max.
// - br_res_i outside BR_WAIT: ignored for PC, sets err_o.
// - Forwarding (combinational, every state): fwd_a_o=01 if regwr_e_i && rd_e_i==rs1_d_i && rs1_d_i!=0;
//   else 10 if regwr_w_i && rd_w_i==rs1_d_i && rs1_d_i!=0; else 00. Execute wins over writeback. Same for B with rs2. x0 never forwarded.
// - PC arithmetic 32-bit, wraps modulo 2^32; no alignment check.
// - rst_n low mid-operation (any state): immediate return to reset values; captured fallthrough discarded; err_o cleared only by reset.
// CONFIGURATION
// - SR_PIPE_CTRL_PERF_EN defined: perf_stall_o +1 each cycle with pc_we_o=0 outside BOOT; perf_br_o +1 per br_res_i&&br_taken_i in BR_WAIT;
//   both saturate at all-ones; perf_clr_i synchronous, priority over increment.
// - Not defined: perf_stall_o/perf_br_o tied to 0, perf_clr_i ignored, no counter flops; all other behaviour identical.
// TESTING
// - Reset release, no branches, pc4_f_i=pc+4: state 00->01, pc_next_o 0,4,8,12 on successive cycles, err_o=0.
// - br_d_i=1 at pc4_d_i=0x14, br_res_i taken tgt=0x40 after 2 cycles: hold/bubble 3 cycles, REDIRECT, pc_next_o=0x40.
// - Same branch, br_taken_i=0: pc_next_o=0x14 after REDIRECT, de_bubble_o=1 in REDIRECT cycle.
// - BR_LAT=2, no br_res_i: err_o=1 after 3 cycles in BR_WAIT, pc_next_o=0x14, returns to RUN.
// - rs1=5, rd_e=5, rd_w=5, both regwr=1 -> fwd_a_o=01; rd_e=0 target rs1=0 -> 00; only rd_w=5 -> 10.
// - PERF_EN, CNT_W=2: 5 stall cycles -> perf_stall_o=3 (saturated); perf_clr_i pulse -> 0; rst_n low in BR_WAIT -> BOOT, outputs at reset values.

Source files
------------

// File: rtl/sr_pipe_ctrl_if.sv
// Bundle of all pipeline-facing signals of the schoolRISCV sequencer.
// master : the sequencer (sr_pipe_ctrl). It drives PC/hold/bubble/forwarding/debug/perf.
// slave  : the pipeline datapath. It drives branch, operand and perf-clear inputs.
// Parameter CNT_W sets the perf counter width and must match the sequencer.
interface sr_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             br_d_i;
  logic [31:0]      pc4_d_i;
  logic [31:0]      pc4_f_i;
  logic             br_res_i;
  logic             br_taken_i;
  logic [31:0]      br_tgt_i;
  logic [4:0]       rs1_d_i;
  logic [4:0]       rs2_d_i;
  logic [4:0]       rd_e_i;
  logic             regwr_e_i;
  logic [4:0]       rd_w_i;
  logic             regwr_w_i;
  logic             perf_clr_i;
  logic [31:0]      pc_next_o;
  logic             pc_we_o;
  logic             fd_hold_o;
  logic             de_bubble_o;
  logic [1:0]       fwd_a_o;
  logic [1:0]       fwd_b_o;
  logic             err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] perf_stall_o;
  logic [CNT_W-1:0] perf_br_o;

  modport master (
    input  br_d_i, pc4_d_i, pc4_f_i, br_res_i, br_taken_i, br_tgt_i,
           rs1_d_i, rs2_d_i, rd_e_i, regwr_e_i, rd_w_i, regwr_w_i, perf_clr_i,
    output pc_next_o, pc_we_o, fd_hold_o, de_bubble_o, fwd_a_o, fwd_b_o,
           err_o, state_o, perf_stall_o, perf_br_o
  );

  modport slave (
    output br_d_i, pc4_d_i, pc4_f_i, br_res_i, br_taken_i, br_tgt_i,
           rs1_d_i, rs2_d_i, rd_e_i, regwr_e_i, rd_w_i, regwr_w_i, perf_clr_i,
    input  pc_next_o, pc_we_o, fd_hold_o, de_bubble_o, fwd_a_o, fwd_b_o,
           err_o, state_o, perf_stall_o, perf_br_o
  );
endinterface

// File: rtl/sr_pipe_ctrl.sv
// Central sequencer for the 4-stage schoolRISCV pipeline.
// It handles PC-next selection, F/D hold, D/E bubble insertion, the branch stall/redirect FSM
// and the operand-forwarding selects.
// Ports: clk, rst_n (async active-low), bus (sr_pipe_ctrl_if.master, all pipeline signals).
// Optional feature: define SR_PIPE_CTRL_PERF_EN to build saturating stall/taken-branch counters.
// Without it, the counter outputs are tied to zero and perf_clr_i is ignored.
// pc_we_o, fd_hold_o, de_bubble_o and fwd_*_o are combinational by design.
// The stage registers need them in the same cycle that the state/operands are presented.
module sr_pipe_ctrl #(
  parameter int unsigned BR_LAT   = 2,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  sr_pipe_ctrl_if.master bus
);
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    BR_WAIT  = 2'b10,
    REDIRECT = 2'b11
  } state_t;

  state_t        state;
  logic [31:0]   pc_next;
  logic [31:0]   fallthrough;
  logic [CW-1:0] cnt;
  logic          err;
  logic          pc_we;
  logic          fd_hold;
  logic          de_bubble;

  // Branch FSM, PC-next register and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_next     <= RESET_PC;
      fallthrough <= 32'h0;
      cnt         <= '0;
      err         <= 1'b0;
    end else begin
      // A resolution that arrives with no branch in flight is a protocol error.
      if (bus.br_res_i && (state != BR_WAIT)) err <= 1'b1;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.br_d_i) begin
            fallthrough <= bus.pc4_d_i;
            cnt         <= CW'(BR_LAT);
            state       <= BR_WAIT;
          end else begin
            pc_next <= bus.pc4_f_i;
          end
        end
        BR_WAIT: begin
          if (bus.br_res_i) begin
            pc_next <= bus.br_taken_i ? bus.br_tgt_i : fallthrough;
            state   <= REDIRECT;
          end else if (cnt == '0) begin
            // Timeout: resume on the fall-through path and flag it.
            err     <= 1'b1;
            pc_next <= fallthrough;
            state   <= REDIRECT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= BOOT;
      endcase
    end
  end

  // Stage enables decoded from state. BOOT fetches only once reset is released.
  always_comb begin
    pc_we     = 1'b0;
    fd_hold   = 1'b1;
    de_bubble = 1'b1;
    case (state)
      BOOT: pc_we = rst_n;
      RUN: begin
        pc_we     = !bus.br_d_i;
        fd_hold   = bus.br_d_i;
        de_bubble = 1'b0;
      end
      REDIRECT: begin
        pc_we   = 1'b1;
        fd_hold = 1'b0;
      end
      default: ;
    endcase
  end

  // Operand forwarding: execute beats writeback, x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0) begin
      if (bus.regwr_e_i && (bus.rd_e_i == rs))      sel = 2'b01;
      else if (bus.regwr_w_i && (bus.rd_w_i == rs)) sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    bus.fwd_a_o = fwd_sel(bus.rs1_d_i);
    bus.fwd_b_o = fwd_sel(bus.rs2_d_i);
  end

  assign bus.pc_next_o   = pc_next;
  assign bus.pc_we_o     = pc_we;
  assign bus.fd_hold_o   = fd_hold;
  assign bus.de_bubble_o = de_bubble;
  assign bus.err_o       = err;
  assign bus.state_o     = state;

`ifdef SR_PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_br;

  // Saturating counters. A clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_br    <= '0;
    end else if (bus.perf_clr_i) begin
      perf_stall <= '0;
      perf_br    <= '0;
    end else begin
      if (!pc_we && (state != BOOT) && (perf_stall != '1))
        perf_stall <= perf_stall + CNT_W'(1);
      if ((state == BR_WAIT) && bus.br_res_i && bus.br_taken_i && (perf_br != '1))
        perf_br <= perf_br + CNT_W'(1);
    end
  end

  assign bus.perf_stall_o = perf_stall;
  assign bus.perf_br_o    = perf_br;
`else
  logic unused_perf_clr;
  assign unused_perf_clr  = bus.perf_clr_i;
  assign bus.perf_stall_o = CNT_W'(0);
  assign bus.perf_br_o    = CNT_W'(0);
`endif

endmodule
